dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single-port data memory `dMEM` between the CPU load/store path (port 0) and a secondary master such as a debug or DMA engine (port 1).
- Each transaction runs through a 3-state FSM: arbitrate, one memory access cycle, response.
- Latched request fields drive the `dMEM` interface.
- Out-of-range addresses return an error and never reach memory.
- Sits between `CPU_TOP`'s core/master side and `dMEM`.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_BYTES, 1024, valid byte range; addresses >= MEM_BYTES are errors.
- FIXED_PRIO, 0, arbitration mode: 0 = round-robin, 1 = port 0 always wins.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pN_req  in  1  request level for port N (N=0,1); held until pN_done.
- pN_we  in  1  1 = store, 0 = load.
- pN_addr  in  ADDR_W  byte address.
- pN_wdata  in  DATA_W  store data.
- pN_s_type  in  3  store funct3 (SB=000, SH=001, SW=010).
- pN_l_type  in  3  load funct3 (LB=000, LH=001, LW=010, LBU=100, LHU=101).
- pN_done  out  1  one-cycle completion pulse for port N.
- pN_err  out  1  qualifies pN_done; address out of range.
- rsp_rdata  out  DATA_W  load result; valid while any pN_done=1.
- busy  out  1  FSM is not IDLE.
- mem_write_en  out  1  to `dMEM`.
- s_type  out  3  to `dMEM`.
- mem_addr  out  ADDR_W  to `dMEM`.
- mem_wdata  out  DATA_W  to `dMEM`.
- l_type  out  3  to `dMEM`.
- mem_rdata  in  DATA_W  combinational read data from `dMEM`.

Behaviour:
- Reset (async, any state, including mid-ACCESS):
  - state=IDLE; owner=0; last_grant=1, so port 0 wins the first tie.
  - All registered fields, rsp_rdata, pN_done, pN_err and busy are 0.
  - mem_* outputs are 0; no write is issued.
- FSM, IDLE:
  - If any pN_req=1, select a winner.
  - Round-robin: the port other than last_grant wins a tie; a lone requester always wins.
  - FIXED_PRIO=1: port 0 wins any tie.
  - On the clock edge: latch the winner's we/addr/wdata/s_type/l_type, set owner and last_grant to the winner, go to ACCESS.
  - If no request, stay in IDLE.
- FSM, ACCESS (exactly 1 cycle):
  - mem_addr/mem_wdata/s_type/l_type are driven from the latched fields.
  - mem_write_en = latched_we & (latched_addr < MEM_BYTES).
  - On the edge: rsp_rdata <= (load & in-range) ? mem_rdata : 0; pN_done/pN_err registered for owner; go to RESP.
- FSM, RESP (1 cycle):
  - p<owner>_done=1; p<owner>_err=1 if the address was out of range.
  - No sampling of requests. Next state IDLE.
- mem_* outputs are 0 in every state except ACCESS.
- Latency: request sampled in cycle N → memory access in N+1 → done in N+2 → next arbitration in N+3. Throughput is 1 transaction per 3 cycles.
- Handshake:
  - Requester holds req and all fields stable until it sees done.
  - It deasserts req, or presents a new request, from cycle N+3.
  - The arbiter latches fields at grant, so changes after grant are ignored.
- Loser of a tie keeps req high and is granted at the next IDLE, guaranteeing no starvation in round-robin mode.
- rsp_rdata holds its value until the next ACCESS capture.
- Out-of-range store: no memory write; err=1, rdata=0.
- Out-of-range load: rdata=0, err=1.
- Address comparison is unsigned on the full ADDR_W width. Alignment is not checked; it is passed through to `dMEM`.
- busy=1 in ACCESS and RESP.
- req deassertion during ACCESS/RESP: the transaction still completes and done still pulses.

Decomposition:
- Package `dmem_arb_pkg`:
  - state enum {IDLE, ACCESS, RESP};
  - funct3 constants for SB/SH/SW/LB/LH/LW/LBU/LHU;
  - a packed struct for request fields {we, addr, wdata, s_type, l_type}.
- Sub-module `rr_arbiter2`: combinational 2-way winner select from req[1:0], last_grant and FIXED_PRIO.
- FSM and registers stay in `dmem_arbiter`.

Test Plan:
- Single store then load:
  - p0 SW addr 0x10 data 0xDEADBEEF → mem_write_en=1 in ACCESS only; p0_done at cycle+2.
  - p0 LW 0x10 → rsp_rdata=0xDEADBEEF with p0_done.
- Simultaneous requests from reset, round-robin:
  - p0 LW 0x4 and p1 LW 0x8 both raised → p0 done first (cycle 2), p1 done at cycle 5.
  - Repeat the tie → p1 granted first.
- FIXED_PRIO=1: p0 issues back-to-back requests every 3 cycles while p1 holds req → p1 never granted until p0 drops req.
- Out of range: p1 SW addr 0x400 (MEM_BYTES=1024) → mem_write_en stays 0; p1_done=1 with p1_err=1, rsp_rdata=0. A memory read at 0x0 shows no change.
- Reset mid-ACCESS: assert reset during ACCESS of p0 SW 0x20 data 0x12345678 → all outputs 0 immediately; later LW 0x20 returns the pre-test value; state is IDLE and the next tie goes to p0.
- Byte types: p0 SB 0x31 data 0xAB, then p0 LBU 0x31 → s_type=000, l_type=100 on the memory port; rsp_rdata=0x000000AB.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dMEM two-port arbiter.
package dmem_arb_pkg;

  // Field widths of the latched request record; the arbiter's ADDR_W/DATA_W must match.
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // RISC-V funct3 encodings for stores and loads.
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic [2:0]            s_type;
    logic [2:0]            l_type;
  } req_fields_t;

  // Unsigned full-width range check against the memory size.
  function automatic logic addr_in_range(input logic [ARB_ADDR_W-1:0] addr,
                                         input logic [ARB_ADDR_W-1:0] limit);
    return (addr < limit);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way winner select: round-robin or fixed port-0 priority.
module rr_arbiter2
  import dmem_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  // Pick the winning port; on a tie the port that did not win last time goes first.
  always_comb begin
    grant_valid = req[0] | req[1];
    grant_idx   = 1'b0;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11: begin
        if (FIXED_PRIO != 0) begin
          grant_idx = 1'b0;
        end else begin
          grant_idx = ~last_grant;
        end
      end
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port dMEM between the CPU load/store path (port 0) and a
// secondary master (port 1). Each transaction: IDLE (grant) -> ACCESS -> RESP.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int MEM_BYTES  = 1024,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [2:0]        p0_s_type,
  input  logic [2:0]        p0_l_type,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [2:0]        p1_s_type,
  input  logic [2:0]        p1_l_type,
  output logic              p0_done,
  output logic              p0_err,
  output logic              p1_done,
  output logic              p1_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              mem_write_en,
  output logic [2:0]        s_type,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        l_type,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

  arb_state_t  state_r;
  logic        owner_r;
  logic        last_grant_r;
  logic        inr_r;
  logic        mem_we_r;
  req_fields_t req_q_r;
  req_fields_t sel_req_s;
  logic        sel_inr_s;
  logic        win_valid_s;
  logic        win_idx_s;

  rr_arbiter2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .req        ({p1_req, p0_req}),
    .last_grant (last_grant_r),
    .grant_valid(win_valid_s),
    .grant_idx  (win_idx_s)
  );

  // Route the winning port's fields toward the grant latch and range-check them.
  always_comb begin
    sel_req_s = {$bits(req_fields_t){1'b0}};
    if (win_idx_s) begin
      sel_req_s.we     = p1_we;
      sel_req_s.addr   = p1_addr;
      sel_req_s.wdata  = p1_wdata;
      sel_req_s.s_type = p1_s_type;
      sel_req_s.l_type = p1_l_type;
    end else begin
      sel_req_s.we     = p0_we;
      sel_req_s.addr   = p0_addr;
      sel_req_s.wdata  = p0_wdata;
      sel_req_s.s_type = p0_s_type;
      sel_req_s.l_type = p0_l_type;
    end
    sel_inr_s = addr_in_range(sel_req_s.addr, MEM_LIMIT);
  end

  // The latched fields are only non-zero during ACCESS, so they drive dMEM directly.
  assign mem_write_en = mem_we_r;
  assign mem_addr     = req_q_r.addr;
  assign mem_wdata    = req_q_r.wdata;
  assign s_type       = req_q_r.s_type;
  assign l_type       = req_q_r.l_type;

  // Transaction FSM with all outputs registered; reset leaves port 0 winning the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      inr_r        <= 1'b0;
      mem_we_r     <= 1'b0;
      req_q_r      <= {$bits(req_fields_t){1'b0}};
      rsp_rdata    <= {DATA_W{1'b0}};
      p0_done      <= 1'b0;
      p0_err       <= 1'b0;
      p1_done      <= 1'b0;
      p1_err       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (win_valid_s) begin
            req_q_r      <= sel_req_s;
            inr_r        <= sel_inr_s;
            mem_we_r     <= sel_req_s.we & sel_inr_s;
            owner_r      <= win_idx_s;
            last_grant_r <= win_idx_s;
            busy         <= 1'b1;
            state_r      <= ACCESS;
          end else begin
            state_r      <= IDLE;
          end
        end
        ACCESS: begin
          // Stores and out-of-range accesses return zero data.
          if (!req_q_r.we && inr_r) begin
            rsp_rdata <= mem_rdata;
          end else begin
            rsp_rdata <= {DATA_W{1'b0}};
          end
          p0_done  <= ~owner_r;
          p0_err   <= ~owner_r & ~inr_r;
          p1_done  <= owner_r;
          p1_err   <= owner_r & ~inr_r;
          mem_we_r <= 1'b0;
          req_q_r  <= {$bits(req_fields_t){1'b0}};
          state_r  <= RESP;
        end
        RESP: begin
          p0_done <= 1'b0;
          p0_err  <= 1'b0;
          p1_done <= 1'b0;
          p1_err  <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          mem_we_r <= 1'b0;
          req_q_r  <= {$bits(req_fields_t){1'b0}};
          p0_done  <= 1'b0;
          p0_err   <= 1'b0;
          p1_done  <= 1'b0;
          p1_err   <= 1'b0;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance on a byte-addressed
// memory model, plus a fixed-priority instance for the priority sequence.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [2:0]  p0_s_type, p0_l_type, p1_s_type, p1_l_type;
  logic        p0_done, p0_err, p1_done, p1_err, busy, mem_write_en;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  s_type, l_type;

  logic        f_p0_req, f_p1_req;
  logic [31:0] f_p0_addr, f_p1_addr;
  logic        f_p0_done, f_p0_err, f_p1_done, f_p1_err, f_busy, f_mem_write_en;
  logic [31:0] f_rsp_rdata, f_mem_addr, f_mem_wdata;
  logic [2:0]  f_s_type, f_l_type;
  logic [31:0] f_mem_rdata = 32'h0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(1024), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_s_type(p0_s_type), .p0_l_type(p0_l_type),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_s_type(p1_s_type), .p1_l_type(p1_l_type),
    .p0_done(p0_done), .p0_err(p0_err), .p1_done(p1_done), .p1_err(p1_err),
    .rsp_rdata(rsp_rdata), .busy(busy), .mem_write_en(mem_write_en),
    .s_type(s_type), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .l_type(l_type), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.MEM_BYTES(1024), .FIXED_PRIO(1)) u_fix (
    .clk(clk), .reset(reset),
    .p0_req(f_p0_req), .p0_we(1'b0), .p0_addr(f_p0_addr), .p0_wdata(32'h0),
    .p0_s_type(3'b000), .p0_l_type(3'b010),
    .p1_req(f_p1_req), .p1_we(1'b0), .p1_addr(f_p1_addr), .p1_wdata(32'h0),
    .p1_s_type(3'b000), .p1_l_type(3'b010),
    .p0_done(f_p0_done), .p0_err(f_p0_err), .p1_done(f_p1_done), .p1_err(f_p1_err),
    .rsp_rdata(f_rsp_rdata), .busy(f_busy), .mem_write_en(f_mem_write_en),
    .s_type(f_s_type), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
    .l_type(f_l_type), .mem_rdata(f_mem_rdata)
  );

  // ---------------- byte-addressed dMEM model (little endian) ----------------
  logic [7:0] mem [0:1023];
  logic       preset_done = 1'b0;
  logic [9:0] wa0, wa1, wa2, wa3;
  assign wa0 = mem_addr[9:0];
  assign wa1 = wa0 + 10'd1;
  assign wa2 = wa0 + 10'd2;
  assign wa3 = wa0 + 10'd3;

  function automatic logic [7:0] preset_byte(input int i);
    logic [31:0] w;
    case (i / 4)
      0:       w = 32'h11223344;
      1:       w = 32'hA5A5A5A5;
      2:       w = 32'h5A5A5A5A;
      8:       w = 32'hCAFEF00D;
      255:     w = 32'h0BADC0DE;
      default: w = 32'h00000000;
    endcase
    return w[8*(i%4) +: 8];
  endfunction

  // Preset contents on the first clock, then apply dMEM writes.
  always @(posedge clk) begin
    if (!preset_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= preset_byte(i);
      preset_done <= 1'b1;
    end else if (mem_write_en) begin
      case (s_type)
        3'b000: mem[wa0] <= mem_wdata[7:0];
        3'b001: begin mem[wa0] <= mem_wdata[7:0]; mem[wa1] <= mem_wdata[15:8]; end
        3'b010: begin
          mem[wa0] <= mem_wdata[7:0];   mem[wa1] <= mem_wdata[15:8];
          mem[wa2] <= mem_wdata[23:16]; mem[wa3] <= mem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  // Combinational read with load-type extension.
  always_comb begin
    case (l_type)
      3'b000:  mem_rdata = {{24{mem[wa0][7]}}, mem[wa0]};
      3'b001:  mem_rdata = {{16{mem[wa1][7]}}, mem[wa1], mem[wa0]};
      3'b010:  mem_rdata = {mem[wa3], mem[wa2], mem[wa1], mem[wa0]};
      3'b100:  mem_rdata = {24'h0, mem[wa0]};
      3'b101:  mem_rdata = {16'h0, mem[wa1], mem[wa0]};
      default: mem_rdata = 32'h0;
    endcase
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] st, input logic [2:0] lt);
    if (port == 1'b0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
      p0_s_type = st; p0_l_type = lt;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
      p1_s_type = st; p1_l_type = lt;
    end
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  st;
    logic [2:0]  lt;
    logic        exp_mwe;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  // One lone-requester transaction, checked in ACCESS, RESP and the following IDLE.
  task automatic do_txn(input vec_t v);
    @(negedge clk);
    drive(v.port, 1'b1, v.we, v.addr, v.wdata, v.st, v.lt);
    @(posedge clk); #1;
    chk("access_busy", {31'h0, busy}, 32'h1);
    chk("access_mem_write_en", {31'h0, mem_write_en}, {31'h0, v.exp_mwe});
    chk("access_mem_addr", mem_addr, v.addr);
    chk("access_mem_wdata", mem_wdata, v.wdata);
    chk("access_s_type", {29'h0, s_type}, {29'h0, v.st});
    chk("access_l_type", {29'h0, l_type}, {29'h0, v.lt});
    @(posedge clk); #1;
    chk("resp_done_owner", {31'h0, (v.port ? p1_done : p0_done)}, 32'h1);
    chk("resp_done_other", {31'h0, (v.port ? p0_done : p1_done)}, 32'h0);
    chk("resp_err", {31'h0, (v.port ? p1_err : p0_err)}, {31'h0, v.exp_err});
    chk("resp_rdata", rsp_rdata, v.exp_rdata);
    @(negedge clk);
    drive(v.port, 1'b0, v.we, v.addr, v.wdata, v.st, v.lt);
    @(posedge clk); #1;
    chk("idle_busy", {31'h0, busy}, 32'h0);
    chk("idle_done", {30'h0, p1_done, p0_done}, 32'h0);
    chk("idle_rdata_held", rsp_rdata, v.exp_rdata);
  endtask

  // Both ports raise LW together; the expected winner completes at +2, the loser at +5.
  task automatic tie(input logic first);
    logic [31:0] a_first, a_second, d_first, d_second;
    a_first  = first ? 32'h8 : 32'h4;
    a_second = first ? 32'h4 : 32'h8;
    d_first  = first ? 32'h5A5A5A5A : 32'hA5A5A5A5;
    d_second = first ? 32'hA5A5A5A5 : 32'h5A5A5A5A;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 3'b000, 3'b010);
    drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 3'b000, 3'b010);
    @(posedge clk); #1;
    chk("tie_first_addr", mem_addr, a_first);
    @(posedge clk); #1;
    chk("tie_first_done", {30'h0, p1_done, p0_done}, first ? 32'h2 : 32'h1);
    chk("tie_first_rdata", rsp_rdata, d_first);
    @(negedge clk);
    if (first) p1_req = 1'b0; else p0_req = 1'b0;
    @(posedge clk); #1;
    chk("tie_gap_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    chk("tie_second_addr", mem_addr, a_second);
    @(posedge clk); #1;
    chk("tie_second_done", {30'h0, p1_done, p0_done}, first ? 32'h1 : 32'h2);
    chk("tie_second_rdata", rsp_rdata, d_second);
    @(negedge clk);
    p0_req = 1'b0; p1_req = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t vecs [13];

  initial begin
    //          port  we    addr            wdata           st      lt      mwe   err   rdata
    vecs[0]  = '{1'b0, 1'b1, 32'h00000010, 32'hDEADBEEF, 3'b010, 3'b000, 1'b1, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b0, 1'b0, 32'h00000010, 32'h00000000, 3'b000, 3'b010, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b1, 32'h00000400, 32'h00000055, 3'b010, 3'b000, 1'b0, 1'b1, 32'h00000000};
    vecs[3]  = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 3'b000, 3'b010, 1'b0, 1'b0, 32'h11223344};
    vecs[4]  = '{1'b0, 1'b1, 32'h00000031, 32'h000000AB, 3'b000, 3'b000, 1'b1, 1'b0, 32'h00000000};
    vecs[5]  = '{1'b0, 1'b0, 32'h00000031, 32'h00000000, 3'b000, 3'b100, 1'b0, 1'b0, 32'h000000AB};
    vecs[6]  = '{1'b1, 1'b0, 32'h00000031, 32'h00000000, 3'b000, 3'b000, 1'b0, 1'b0, 32'hFFFFFFAB};
    vecs[7]  = '{1'b1, 1'b1, 32'h00000012, 32'h1234BEEF, 3'b001, 3'b000, 1'b1, 1'b0, 32'h00000000};
    vecs[8]  = '{1'b1, 1'b0, 32'h00000012, 32'h00000000, 3'b000, 3'b101, 1'b0, 1'b0, 32'h0000BEEF};
    vecs[9]  = '{1'b0, 1'b0, 32'h00000012, 32'h00000000, 3'b000, 3'b001, 1'b0, 1'b0, 32'hFFFFBEEF};
    vecs[10] = '{1'b0, 1'b0, 32'h00000010, 32'h00000000, 3'b000, 3'b010, 1'b0, 1'b0, 32'hBEEFBEEF};
    vecs[11] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h00000000, 3'b000, 3'b010, 1'b0, 1'b1, 32'h00000000};
    vecs[12] = '{1'b0, 1'b0, 32'h000003FC, 32'h00000000, 3'b000, 3'b010, 1'b0, 1'b0, 32'h0BADC0DE};

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 3'b000);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 3'b000);
    f_p0_req = 1'b0; f_p1_req = 1'b0; f_p0_addr = 32'h0; f_p1_addr = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done_err", {28'h0, p1_err, p1_done, p0_err, p0_done}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_we", {31'h0, mem_write_en}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Round-robin ties: first from reset goes to p0; after a lone p0 grant, p1 wins.
    tie(1'b0);
    do_txn('{1'b0, 1'b0, 32'h4, 32'h0, 3'b000, 3'b010, 1'b0, 1'b0, 32'hA5A5A5A5});
    tie(1'b1);

    for (int i = 0; i < 13; i++) do_txn(vecs[i]);

    // Reset in the middle of an ACCESS store: outputs clear at once and no write lands.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678, 3'b010, 3'b000);
    @(posedge clk); #2;
    chk("mid_pre_mem_we", {31'h0, mem_write_en}, 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_mem_we", {31'h0, mem_write_en}, 32'h0);
    chk("mid_rst_mem_addr", mem_addr, 32'h0);
    chk("mid_rst_mem_wdata", mem_wdata, 32'h0);
    chk("mid_rst_s_type", {29'h0, s_type}, 32'h0);
    chk("mid_rst_rdata", rsp_rdata, 32'h0);
    chk("mid_rst_done", {30'h0, p1_done, p0_done}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 3'b000);
    tie(1'b0);
    do_txn('{1'b0, 1'b0, 32'h20, 32'h0, 3'b000, 3'b010, 1'b0, 1'b0, 32'hCAFEF00D});

    // Fixed priority: p0 back-to-back every 3 cycles starves p1 until p0 drops req.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      f_p0_addr = 32'h100 + 32'(4 * k);
      if (k == 0) begin
        f_p0_req = 1'b1; f_p1_req = 1'b1; f_p1_addr = 32'h200;
      end
      @(posedge clk); #1;
      chk("fix_p0_addr", f_mem_addr, 32'h100 + 32'(4 * k));
      @(posedge clk); #1;
      chk("fix_p0_done", {30'h0, f_p1_done, f_p0_done}, 32'h1);
      @(posedge clk); #1;
      chk("fix_idle_busy", {31'h0, f_busy}, 32'h0);
    end
    @(negedge clk);
    f_p0_req = 1'b0;
    @(posedge clk); #1;
    chk("fix_p1_addr", f_mem_addr, 32'h200);
    @(posedge clk); #1;
    chk("fix_p1_done", {30'h0, f_p1_done, f_p0_done}, 32'h2);
    @(negedge clk);
    f_p1_req = 1'b0;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
